// File: rtl/router_pkg.sv
// Shared defaults and width derivations for the router sync/timeout block.
package router_pkg;

    localparam int DEF_NCH     = 3;
    localparam int DEF_TIMEOUT = 30;

    // At least one address bit even for a two-channel router.
    function automatic int calc_addr_w(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

    function automatic int calc_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/router_sync_tmo.sv
// Per-channel stall timer: one-cycle soft-reset pulse after TIMEOUT stall cycles,
// sticky flag, and an optional saturating pulse counter (ROUTER_SYNC_STATS_EN).
module router_sync_tmo #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       sr_clr,
`ifdef ROUTER_SYNC_STATS_EN
    output logic [7:0] to_cnt,
`endif
    output logic       sr,
    output logic       sr_sticky
);

    logic [CNT_W-1:0] cnt;
    logic             hit;

    assign hit = stall && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sr  <= 1'b0;
        end else if (!stall) begin
            cnt <= '0;
            sr  <= 1'b0;
        end else if (hit) begin
            cnt <= '0;
            sr  <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            sr  <= 1'b0;
        end
    end

    // A timeout landing on the same edge as sr_clr must stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr_sticky <= 1'b0;
        else if (hit)
            sr_sticky <= 1'b1;
        else if (sr_clr)
            sr_sticky <= 1'b0;
    end

`ifdef ROUTER_SYNC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (sr_clr)
            to_cnt <= hit ? 8'd1 : 8'd0;
        else if (hit && to_cnt != 8'hff)
            to_cnt <= to_cnt + 8'd1;
    end
`endif

endmodule

// File: rtl/router_sync_mc.sv
// Router synchronizer: captures destination address, steers write enable/full
// flag, and runs per-channel stall timeouts. Optional stats via ROUTER_SYNC_STATS_EN.
module router_sync_mc
    import router_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ADDR_W = calc_addr_w(NCH),
    localparam int CNT_W  = calc_cnt_w(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_addr,
    input  logic              write_enb_reg,
    input  logic [ADDR_W-1:0] din,
    input  logic [NCH-1:0]    re,
    input  logic [NCH-1:0]    empty,
    input  logic [NCH-1:0]    full,
    input  logic              sr_clr,
    output logic [NCH-1:0]    we,
    output logic              fifo_full,
    output logic [NCH-1:0]    vo,
    output logic [NCH-1:0]    sr,
    output logic              addr_err,
`ifdef ROUTER_SYNC_STATS_EN
    output logic [NCH*8-1:0]  to_cnt,
`endif
    output logic [NCH-1:0]    sr_sticky
);

    logic [ADDR_W-1:0] addr;
    logic              addr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            addr_valid <= 1'b1;
        end else if (detect_addr) begin
            addr       <= din;
            addr_valid <= (32'(din) < 32'(NCH));
        end
    end

    // Out-of-range destinations never get a write strobe and always look full.
    always_comb begin
        we        = '0;
        fifo_full = 1'b1;
        if (addr_valid) begin
            fifo_full = full[addr];
            if (write_enb_reg)
                we[addr] = 1'b1;
        end
    end

    assign addr_err = ~addr_valid;
    assign vo       = ~empty;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        router_sync_tmo #(
            .TIMEOUT(TIMEOUT),
            .CNT_W  (CNT_W)
        ) u_tmo (
            .clk      (clk),
            .rst      (rst),
            .stall    (vo[i] & ~re[i]),
            .sr_clr   (sr_clr),
`ifdef ROUTER_SYNC_STATS_EN
            .to_cnt   (to_cnt[i*8 +: 8]),
`endif
            .sr       (sr[i]),
            .sr_sticky(sr_sticky[i])
        );
    end

endmodule

// File: tb/tb_router_sync_mc.sv
// Directed self-checking bench for router_sync_mc (NCH=3, TIMEOUT=30).
module tb_router_sync_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       detect_addr;
    logic       write_enb_reg;
    logic [1:0] din;
    logic [2:0] re;
    logic [2:0] empty;
    logic [2:0] full;
    logic       sr_clr;
    logic [2:0] we;
    logic       fifo_full;
    logic [2:0] vo;
    logic [2:0] sr;
    logic       addr_err;
    logic [2:0] sr_sticky;
`ifdef ROUTER_SYNC_STATS_EN
    logic [23:0] to_cnt;
`endif

    int checks = 0;
    int errors = 0;

    router_sync_mc #(.NCH(3), .TIMEOUT(30)) dut (
        .clk          (clk),
        .rst          (rst),
        .detect_addr  (detect_addr),
        .write_enb_reg(write_enb_reg),
        .din          (din),
        .re           (re),
        .empty        (empty),
        .full         (full),
        .sr_clr       (sr_clr),
        .we           (we),
        .fifo_full    (fifo_full),
        .vo           (vo),
        .sr           (sr),
        .addr_err     (addr_err),
`ifdef ROUTER_SYNC_STATS_EN
        .to_cnt       (to_cnt),
`endif
        .sr_sticky    (sr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; detect_addr = 1'b0; write_enb_reg = 1'b0; din = 2'd0;
        re = 3'b000; empty = 3'b111; full = 3'b000; sr_clr = 1'b0;
        tick(); tick();
        chk("rst_sr", 32'(sr), 32'h0);
        chk("rst_sticky", 32'(sr_sticky), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        write_enb_reg = 1'b1; full = 3'b001; #1;
        chk("rst_we_addr0", 32'(we), 32'h1);
        chk("rst_full_addr0", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0; full = 3'b000;
        rst = 1'b0;
        tick();

        // Valid destination 2
        detect_addr = 1'b1; din = 2'd2;
        tick();
        detect_addr = 1'b0; write_enb_reg = 1'b1; #1;
        chk("we_ch2", 32'(we), 32'h4);
        chk("full_ch2_clear", 32'(fifo_full), 32'h0);
        full = 3'b100; #1;
        chk("full_ch2_set", 32'(fifo_full), 32'h1);
        full = 3'b011; #1;
        chk("full_ch2_others", 32'(fifo_full), 32'h0);
        chk("addr_err_valid", 32'(addr_err), 32'h0);

        // New address while writing: old address this cycle, new one next
        detect_addr = 1'b1; din = 2'd1; #1;
        chk("we_old_addr", 32'(we), 32'h4);
        tick();
        detect_addr = 1'b0; #1;
        chk("we_new_addr", 32'(we), 32'h2);
        chk("full_ch1", 32'(fifo_full), 32'h1);

        // Invalid destination 3
        detect_addr = 1'b1; din = 2'd3; full = 3'b000;
        tick();
        detect_addr = 1'b0; #1;
        chk("addr_err_inv", 32'(addr_err), 32'h1);
        chk("we_inv", 32'(we), 32'h0);
        chk("full_inv", 32'(fifo_full), 32'h1);
        detect_addr = 1'b1; din = 2'd0;
        tick();
        detect_addr = 1'b0; #1;
        chk("addr_err_back", 32'(addr_err), 32'h0);
        chk("we_ch0", 32'(we), 32'h1);
        write_enb_reg = 1'b0;

        empty = 3'b010; #1;
        chk("vo_pattern", 32'(vo), 32'h5);
        empty = 3'b111; #1;
        chk("vo_idle", 32'(vo), 32'h0);

        // Channel 1 stalled for 60 edges
        empty = 3'b101; re = 3'b000;
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk($sformatf("sr_ch1_e%0d", k), 32'(sr), (k == 30 || k == 60) ? 32'h2 : 32'h0);
        end
        empty = 3'b111;
        tick();
        chk("sr_after_stall", 32'(sr), 32'h0);
        chk("sticky_ch1", 32'(sr_sticky), 32'h2);
        sr_clr = 1'b1;
        tick();
        sr_clr = 1'b0;
        chk("sticky_cleared", 32'(sr_sticky), 32'h0);

        // Channel 0: 29 stall cycles, one read, 29 more
        empty = 3'b110; re = 3'b000;
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk($sformatf("sr_ch0_a%0d", k), 32'(sr), 32'h0);
        end
        re = 3'b001;
        tick();
        re = 3'b000;
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk($sformatf("sr_ch0_b%0d", k), 32'(sr), 32'h0);
        end
        empty = 3'b111;
        tick();
        chk("sticky_ch0_none", 32'(sr_sticky), 32'h0);

        // Channel 2: reset after 20 stall cycles, then 30 more
        empty = 3'b011;
        for (int k = 1; k <= 20; k++) tick();
        rst = 1'b1; #1;
        chk("mid_rst_sr", 32'(sr), 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("sr_ch2_e%0d", k), 32'(sr), (k == 30) ? 32'h4 : 32'h0);
        end
        empty = 3'b111;
        tick();
        chk("sticky_ch2", 32'(sr_sticky), 32'h4);

`ifdef ROUTER_SYNC_STATS_EN
        sr_clr = 1'b1;
        tick();
        sr_clr = 1'b0;
        empty = 3'b110;
        for (int k = 1; k <= 300 * 30; k++) tick();
        empty = 3'b111;
        tick();
        chk("stats_sat", 32'(to_cnt[7:0]), 32'hff);
        chk("stats_sticky", 32'(sr_sticky[0]), 32'h1);
        sr_clr = 1'b1;
        tick();
        sr_clr = 1'b0;
        chk("stats_clr", 32'(to_cnt[7:0]), 32'h0);
        chk("stats_sticky_clr", 32'(sr_sticky[0]), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
